instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Requester side of the instruction memory/cache interface.
- Generates the fetch address and consumes the returned word plus the instr_miss_f / instr_cache_rep_en status.
- Tracks miss/refill state and buffers fetched instructions in a small FIFO.
- Hands each instruction and its PC to decode over a valid/ready handshake; branch/jump redirects flush the buffer.

Parameters:
- RESET_PC, 32'h0000_0000: fetch address loaded on reset; must be word aligned.
- FIFO_DEPTH, 4: instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset_n  input  1  synchronous active-low reset
- imem_addr_o  output  32  fetch address to instruction memory
- imem_rd_i  input  32  instruction word returned for imem_addr_o, same cycle
- instr_miss_f_i  input  1  1 = imem_rd_i invalid this cycle
- instr_cache_rep_en_i  input  1  1 = memory side is performing or permitting line replacement
- redirect_en_i  input  1  1 = load redirect_pc_i and flush
- redirect_pc_i  input  32  redirect target
- instr_valid_o  output  1  buffer head valid
- instr_o  output  32  buffer head instruction; 0 when instr_valid_o=0
- instr_pc_o  output  32  buffer head PC; 0 when instr_valid_o=0
- instr_ready_i  input  1  decode accepts head this cycle
- fetch_stall_o  output  1  1 when FSM is not in FETCH
- miss_cnt_o  output  32  saturating count of cycles with instr_miss_f_i=1

Behaviour:
- Reset, sampled on a clk edge with reset_n=0:
  - fetch_pc=RESET_PC, FIFO count=0, rd/wr pointers=0, FSM=FETCH, miss_cnt=0.
  - Hence instr_valid_o=0, instr_o=0, instr_pc_o=0, fetch_stall_o=0, imem_addr_o=RESET_PC.
  - Reset overrides every other input, including mid-miss and mid-redirect.
- Address generation: imem_addr_o = fetch_pc, driven directly from the register, no combinational input path.
- Accept condition: accept = !redirect_en_i && !instr_miss_f_i && (count < FIFO_DEPTH).
  - Full is judged on the count before any same-cycle pop: a full FIFO blocks the push even when a pop occurs in that cycle.
- On accept:
  - Push {fetch_pc, imem_rd_i}.
  - fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- Fetch latency: a word present at cycle N with no miss appears at the FIFO head at cycle N+1 if the FIFO was empty.
- Pop: when instr_valid_o && instr_ready_i && !redirect_en_i; the head advances.
- Simultaneous push and pop with a non-full FIFO: count unchanged.
- Order: FIFO preserves fetch order; pointers wrap modulo FIFO_DEPTH.
- Redirect has highest priority after reset:
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - count <= 0 and pointers <= 0.
  - No push or pop that cycle.
  - FSM <= FETCH.
  - The first post-redirect instruction is fetched the next cycle.
- FSM (state transitions are suppressed in a redirect cycle, since the redirect forces FETCH):
  - FETCH: miss=1 -> MISS_WAIT; else stay.
  - MISS_WAIT: rep_en=1 -> REFILL; else stay, even if miss drops, because the word is not trusted until refill.
  - REFILL: miss=0 -> FETCH, and accept is allowed this cycle; else stay.
- Accept gating by state: accept is additionally gated to FETCH or REFILL; in MISS_WAIT no push occurs.
- fetch_stall_o = (state != FETCH).
- miss_cnt: +1 on every non-reset cycle with instr_miss_f_i=1, independent of redirect; saturates at 32'hFFFF_FFFF.
- Misaligned input: redirect_pc_i[1:0] are ignored.

Test Plan:
- Reset release, miss=0, ready=1, memory holds word (addr>>2) -> instr_pc_o sequence 0,4,8,12 on consecutive cycles after a 1-cycle latency; instr_o matches; fetch_stall_o=0.
- ready=0 for 10 cycles with FIFO_DEPTH=4 -> count reaches 4, imem_addr_o holds at 32'h10, then ready=1 drains PCs 0,4,8,12 with no gap or duplicate.
- miss=1 for 3 cycles, rep_en=0 for 2 then 1, then miss=0:
  - States FETCH -> MISS_WAIT -> MISS_WAIT -> REFILL -> FETCH.
  - miss_cnt=3.
  - No push in miss cycles; the address is held.
- Redirect to 32'h0000_0102 while the FIFO holds 3 entries and ready=1 -> next cycle instr_valid_o=0, imem_addr_o=32'h100; following cycle head pc=32'h100.
- Redirect asserted during MISS_WAIT -> FSM=FETCH next cycle, fetch_stall_o=0, miss_cnt keeps counting any same-cycle miss.
- fetch_pc forced near the top via redirect to 32'hFFFF_FFF8 -> pushed PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- reset_n=0 mid-refill with a full FIFO -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch requester: drives the fetch address, tracks miss/refill
// status and buffers fetched words for decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rd_i,
    input  logic        instr_miss_f_i,
    input  logic        instr_cache_rep_en_i,
    input  logic        redirect_en_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        fetch_stall_o,
    output logic [31:0] miss_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        FETCH,
        MISS_WAIT,
        REFILL
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     fetch_pc;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [31:0]     pc_buf    [FIFO_DEPTH];
    logic [31:0]     instr_buf [FIFO_DEPTH];
    logic [31:0]     miss_cnt;

    logic            full;
    logic            state_ok;
    logic            accept;
    logic            pop;
    logic            head_valid;
    logic            unused_pc_bits;

    // Redirect targets are forced word aligned; the low bits carry no meaning.
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    assign full       = (count == CW'(FIFO_DEPTH));
    assign head_valid = (count != '0);
    assign state_ok   = (state == FETCH) || (state == REFILL);

    // Full is judged before any same-cycle pop, so a full buffer never pushes.
    assign accept = !redirect_en_i && !instr_miss_f_i && !full && state_ok;
    assign pop    = head_valid && instr_ready_i && !redirect_en_i;

    always_comb begin
        state_nxt = state;
        unique case (state)
            FETCH: begin
                if (instr_miss_f_i) begin
                    state_nxt = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (instr_cache_rep_en_i) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                if (!instr_miss_f_i) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
        end else if (redirect_en_i) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_en_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        end else if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_en_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !accept) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            pc_buf[wr_ptr]    <= fetch_pc;
            instr_buf[wr_ptr] <= imem_rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            miss_cnt <= '0;
        end else if (instr_miss_f_i && (miss_cnt != 32'hFFFF_FFFF)) begin
            miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? instr_buf[rd_ptr] : 32'h0;
    assign instr_pc_o    = head_valid ? pc_buf[rd_ptr] : 32'h0;
    assign fetch_stall_o = (state != FETCH);
    assign miss_cnt_o    = miss_cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a reference model predicts pushes,
// expected entries are queued and compared as decode pops them.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rd_i;
    logic        instr_miss_f_i;
    logic        instr_cache_rep_en_i;
    logic        redirect_en_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        fetch_stall_o;
    logic [31:0] miss_cnt_o;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .imem_addr_o         (imem_addr_o),
        .imem_rd_i           (imem_rd_i),
        .instr_miss_f_i      (instr_miss_f_i),
        .instr_cache_rep_en_i(instr_cache_rep_en_i),
        .redirect_en_i       (redirect_en_i),
        .redirect_pc_i       (redirect_pc_i),
        .instr_valid_o       (instr_valid_o),
        .instr_o             (instr_o),
        .instr_pc_o          (instr_pc_o),
        .instr_ready_i       (instr_ready_i),
        .fetch_stall_o       (fetch_stall_o),
        .miss_cnt_o          (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory holds word (addr>>2); during a miss the returned data is junk.
    always_comb begin
        imem_rd_i = instr_miss_f_i ? 32'hBAD0_BAD0 : (imem_addr_o >> 2);
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_miss;
    int          ms;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic cycle();
        logic acc;
        logic pp;
        check("addr", imem_addr_o, m_pc);
        check("stall", 32'(fetch_stall_o), 32'(ms != 0));
        check("valid", 32'(instr_valid_o), 32'(sb.size() > 0));
        check("miss_cnt", miss_cnt_o, m_miss);
        if (sb.size() > 0) begin
            check("instr", instr_o, sb[0][31:0]);
            check("pc", instr_pc_o, sb[0][63:32]);
        end else begin
            check("instr_idle", instr_o, 32'h0);
            check("pc_idle", instr_pc_o, 32'h0);
        end
        if (!reset_n) begin
            sb.delete();
            m_pc   = 32'h0;
            m_miss = 32'h0;
            ms     = 0;
        end else begin
            acc = !redirect_en_i && !instr_miss_f_i && (sb.size() < DEPTH)
                  && (ms != 1);
            pp  = (sb.size() > 0) && instr_ready_i && !redirect_en_i;
            if (instr_miss_f_i && m_miss != 32'hFFFF_FFFF) m_miss++;
            if (redirect_en_i) begin
                sb.delete();
                m_pc = {redirect_pc_i[31:2], 2'b00};
                ms   = 0;
            end else begin
                if (pp) void'(sb.pop_front());
                if (acc) begin
                    sb.push_back({m_pc, m_pc >> 2});
                    m_pc = m_pc + 32'd4;
                end
                case (ms)
                    0: if (instr_miss_f_i) ms = 1;
                    1: if (instr_cache_rep_en_i) ms = 2;
                    default: if (!instr_miss_f_i) ms = 0;
                endcase
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_miss_f_i       = 1'b0;
        instr_cache_rep_en_i = 1'b0;
        redirect_en_i        = 1'b0;
        redirect_pc_i        = 32'h0;
        instr_ready_i        = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        m_pc   = 32'h0;
        m_miss = 32'h0;
        ms     = 0;
        @(posedge clk);
        @(negedge clk);

        // Streaming fetch
        do_reset();
        run(6);

        // Backpressure fills the buffer, then drains in order
        do_reset();
        instr_ready_i = 1'b0;
        run(10);
        check("full_addr", imem_addr_o, 32'h10);
        instr_ready_i = 1'b1;
        run(6);

        // Miss, wait, refill, resume
        do_reset();
        run(2);
        instr_miss_f_i = 1'b1;
        run(2);
        instr_cache_rep_en_i = 1'b1;
        run(1);
        instr_cache_rep_en_i = 1'b0;
        instr_miss_f_i       = 1'b0;
        check("refill_stall", 32'(fetch_stall_o), 32'd1);
        run(1);
        check("miss_cnt3", miss_cnt_o, 32'd3);
        run(3);

        // Redirect with three buffered entries
        do_reset();
        instr_ready_i = 1'b0;
        run(3);
        instr_ready_i = 1'b1;
        redirect_en_i = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        run(1);
        redirect_en_i = 1'b0;
        check("redir_addr", imem_addr_o, 32'h100);
        run(1);
        check("redir_head", instr_pc_o, 32'h100);
        run(3);

        // Redirect during MISS_WAIT with a same-cycle miss
        instr_miss_f_i = 1'b1;
        run(2);
        redirect_en_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        run(1);
        redirect_en_i  = 1'b0;
        instr_miss_f_i = 1'b0;
        check("redir_stall", 32'(fetch_stall_o), 32'd0);
        run(3);

        // Address wrap at the top of memory
        redirect_en_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        instr_ready_i = 1'b0;
        run(1);
        redirect_en_i = 1'b0;
        run(3);
        instr_ready_i = 1'b1;
        run(4);

        // Reset mid-refill with a full buffer
        instr_ready_i = 1'b0;
        run(5);
        instr_miss_f_i = 1'b1;
        run(1);
        instr_cache_rep_en_i = 1'b1;
        run(1);
        reset_n = 1'b0;
        run(1);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_miss", miss_cnt_o, 32'd0);
        reset_n = 1'b1;
        idle_inputs();
        run(2);

        // Randomised mix
        for (int i = 0; i < 400; i++) begin
            instr_miss_f_i       = ($urandom_range(0, 9) < 3);
            instr_cache_rep_en_i = ($urandom_range(0, 1) == 1);
            instr_ready_i        = ($urandom_range(0, 9) < 6);
            redirect_en_i        = ($urandom_range(0, 29) == 0);
            redirect_pc_i        = $urandom;
            reset_n              = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset_n = 1'b1;
        idle_inputs();
        run(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
